// File: rtl/por_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// por_ctrl_pkg
// Shared definitions for the power-on reset sequencer:
//   - STATE_W      : width of the debug state code
//   - ST_* codes   : numeric state codes exposed on state_o
//   - state_e      : FSM state type built on those codes
//   - DEF_*        : default filter / step lengths in clk cycles
// -----------------------------------------------------------------------------
package por_ctrl_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_HOLD    = 3'd0;
    localparam logic [STATE_W-1:0] ST_FILTER  = 3'd1;
    localparam logic [STATE_W-1:0] ST_RELEASE = 3'd2;
    localparam logic [STATE_W-1:0] ST_RUN     = 3'd3;
    localparam logic [STATE_W-1:0] ST_DRAIN   = 3'd4;

    localparam int DEF_FILTER_CYCLES = 8;
    localparam int DEF_STEP_CYCLES   = 16;

    typedef enum logic [STATE_W-1:0] {
        HOLD    = ST_HOLD,
        FILTER  = ST_FILTER,
        RELEASE = ST_RELEASE,
        RUN     = ST_RUN,
        DRAIN   = ST_DRAIN
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Single-bit two-flop synchronizer for an asynchronous level input.
// Both flops clear to 0 on the synchronous active-high reset.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset
//   d_i  - asynchronous input
//   q_o  - synchronized output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/por_reset_sequencer.sv
// -----------------------------------------------------------------------------
// por_reset_sequencer
// Turns the raw asynchronous POR-bar into glitch-filtered, ordered, synchronous
// active-low resets for N_DOMAINS domains. Domains are released lowest first
// with STEP_CYCLES between steps and re-asserted highest first on a 4-phase
// soft-reset request. Loss of porb drops every domain at once.
// Ports:
//   clk         - single clock
//   rst         - synchronous active-high reset
//   porb_i      - asynchronous POR-bar (1 = supply good)
//   soft_req_i  - soft-reset request level
//   soft_ack_o  - soft-reset acknowledge
//   rst_n_o     - per-domain active-low resets, thermometer coded from bit 0
//   ready_o     - high in every RUN cycle
//   state_o     - registered state code
// -----------------------------------------------------------------------------
module por_reset_sequencer
    import por_ctrl_pkg::*;
#(
    parameter int N_DOMAINS     = 4,
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int STEP_CYCLES   = DEF_STEP_CYCLES,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 porb_i,
    input  logic                 soft_req_i,
    output logic                 soft_ack_o,
    output logic [N_DOMAINS-1:0] rst_n_o,
    output logic                 ready_o,
    output logic [STATE_W-1:0]   state_o
);

    localparam logic [CNT_W-1:0]     FILTER_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0]     STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
    localparam logic [N_DOMAINS-1:0] ALL_ON      = '1;
    localparam logic [N_DOMAINS-1:0] LSB_ON      = N_DOMAINS'(1);

    logic                 porb_s;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_DOMAINS-1:0] rst_n_q, rst_n_d;
    logic                 ack_q, ack_d;
    logic                 ready_q, ready_d;
    logic [N_DOMAINS-1:0] grown_s;
    logic [N_DOMAINS-1:0] shrunk_s;

    sync_2ff u_porb_sync (
        .clk (clk),
        .rst (rst),
        .d_i (porb_i),
        .q_o (porb_s)
    );

    // Thermometer code: growing sets the lowest clear bit, shrinking clears the
    // highest set bit.
    assign grown_s  = (rst_n_q << 1) | LSB_ON;
    assign shrunk_s = rst_n_q >> 1;

    // Next-state, counter, reset vector and acknowledge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_n_d = rst_n_q;
        // Acknowledge drops one cycle after the request is seen low.
        if (ack_q && !soft_req_i) begin
            ack_d = 1'b0;
        end else begin
            ack_d = ack_q;
        end

        if (!porb_s) begin
            // Brown-out: drop everything at once, no sequencing.
            state_d = HOLD;
            cnt_d   = '0;
            rst_n_d = '0;
            ack_d   = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    cnt_d   = '0;
                    rst_n_d = '0;
                    if (ack_q) begin
                        state_d = HOLD;
                    end else if (soft_req_i) begin
                        ack_d = 1'b1;
                    end else begin
                        state_d = FILTER;
                    end
                end
                FILTER: begin
                    if (soft_req_i) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        ack_d   = 1'b1;
                    end else if (cnt_q == FILTER_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RELEASE: begin
                    if (soft_req_i) begin
                        // Drain starts from whatever has been released so far.
                        cnt_d   = '0;
                        rst_n_d = shrunk_s;
                        if (shrunk_s == '0) begin
                            state_d = HOLD;
                            ack_d   = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else if (cnt_q == STEP_LAST) begin
                        cnt_d   = '0;
                        rst_n_d = grown_s;
                        if (grown_s == ALL_ON) begin
                            state_d = RUN;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                RUN: begin
                    cnt_d = '0;
                    if (soft_req_i) begin
                        rst_n_d = shrunk_s;
                        if (shrunk_s == '0) begin
                            state_d = HOLD;
                            ack_d   = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        state_d = RUN;
                    end
                end
                DRAIN: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d   = '0;
                        rst_n_d = shrunk_s;
                        if (shrunk_s == '0) begin
                            state_d = HOLD;
                            ack_d   = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    rst_n_d = '0;
                    ack_d   = 1'b0;
                end
            endcase
        end
    end

    assign ready_d = (state_d == RUN);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            rst_n_q <= '0;
            ack_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= rst_n_d;
            ack_q   <= ack_d;
            ready_q <= ready_d;
        end
    end

    assign rst_n_o    = rst_n_q;
    assign ready_o    = ready_q;
    assign soft_ack_o = ack_q;
    assign state_o    = state_q;

endmodule
